ps2_key_decoder: RTL and testbench

- Upstream input stage of the game processor: receives the raw PS/2 keyboard clock/data lines.
- Deframes 11-bit device-to-host frames and resolves the E0 (extended) and F0 (break) prefixes.
- Presents one decoded key event as keycode / key_make / key_ext, plus a one-cycle key_valid strobe, to the processor's key register.

---
 rtl/ps2_pkg.sv | 32 +++
 rtl/ps2_line_filter.sv | 69 ++++++
 rtl/ps2_key_decoder.sv | 186 ++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard front end.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_e;

    // Prefix bytes that modify the following scan code
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    // Keyboard housekeeping replies, never reported as keys on their own
    localparam logic [7:0] PS2_NULL    = 8'h00;
    localparam logic [7:0] PS2_OVERRUN = 8'hFF;
    localparam logic [7:0] PS2_BAT_OK  = 8'hAA;
    localparam logic [7:0] PS2_ACK     = 8'hFA;

    // Default tuning: 1 ms frame timeout at 50 MHz
    localparam int PS2_FILTER_LEN_DEF = 4;
    localparam int PS2_TIMEOUT_DEF    = 50000;
    localparam int PS2_SYNC_DEF       = 2;

    function automatic logic is_suppressed(input logic [7:0] code);
        return (code == PS2_NULL) || (code == PS2_OVERRUN) ||
               (code == PS2_BAT_OK) || (code == PS2_ACK);
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes the raw PS/2 lines, deglitches the clock and emits a
// one-cycle strobe on each filtered falling edge of ps2_clk.
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = PS2_FILTER_LEN_DEF,
    parameter int SYNC_STAGES = PS2_SYNC_DEF       // must be >= 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic ps2_clk_i,
    input  logic ps2_dat_i,
    output logic fall_o,
    output logic dat_o
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   fall_q, fall_d;
    logic                   clk_s;

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign dat_o  = dat_sync_q[SYNC_STAGES-1];
    assign fall_o = fall_q;

    // Synchronizer chains; reset to the idle-high line level
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_dat_i};
        end
    end

    // Count consecutive samples that disagree with the filtered level;
    // the level flips on the FILTER_LEN-th one, any agreeing sample restarts
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (clk_s != level_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                level_d = clk_s;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        fall_d = level_q & ~level_d;
    end

    // Filter state and registered fall strobe
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q <= 1'b1;
            cnt_q   <= '0;
            fall_q  <= 1'b0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
            fall_q  <= fall_d;
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: deframes device-to-host frames, resolves the
// E0/F0 prefixes and presents one key event per key_valid strobe.
//
//   state  | meaning
//   IDLE   | waiting for the start bit fall
//   DATA   | shifting in 8 data bits, LSB first
//   PARITY | next fall carries the odd parity bit
//   STOP   | next fall carries the stop bit; frame is checked there
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = PS2_FILTER_LEN_DEF,
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_DEF,   // must be >= 2
    parameter int SYNC_STAGES    = PS2_SYNC_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] keycode,
    output logic       key_make,
    output logic       key_ext,
    output logic       key_valid,
    output logic       frame_err
);

    localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
    // Loaded in the fall cycle so the error strobe lands exactly
    // TIMEOUT_CYCLES cycles after that fall
    localparam logic [TW-1:0]  TMO_LOAD = TW'(TIMEOUT_CYCLES - 2);

    logic         fall;
    logic         dat;

    frame_state_e state_q, state_d;
    logic [2:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]   shift_q, shift_d;
    logic         par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic         ext_q, ext_d;
    logic         brk_q, brk_d;
    logic [7:0]   keycode_q, keycode_d;
    logic         make_q, make_d;
    logic         kext_q, kext_d;
    logic         valid_q, valid_d;
    logic         err_q, err_d;

    logic         timeout_hit;
    logic         stop_ok;
    logic         byte_rdy;
    logic         stop_err;
    logic         start_err;

    ps2_line_filter #(
        .FILTER_LEN  (FILTER_LEN),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_line (
        .clk_i     (clk),
        .rst_ni    (reset),
        .ps2_clk_i (ps2_clk),
        .ps2_dat_i (ps2_dat),
        .fall_o    (fall),
        .dat_o     (dat)
    );

    // A fall always reloads the timer, so it can only expire between falls
    assign timeout_hit = (state_q != IDLE) && !fall && (tmo_q == '0);
    assign stop_ok     = dat && (^{shift_q, par_q});
    assign byte_rdy    = fall && (state_q == STOP) && stop_ok;
    assign stop_err    = fall && (state_q == STOP) && !stop_ok;
    assign start_err   = fall && (state_q == IDLE) && dat;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tmo_q     <= '0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            keycode_q <= '0;
            make_q    <= 1'b0;
            kext_q    <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tmo_q     <= tmo_d;
            ext_q     <= ext_d;
            brk_q     <= brk_d;
            keycode_q <= keycode_d;
            make_q    <= make_d;
            kext_q    <= kext_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    // Frame FSM next state, bit shifting and timeout down-counter
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tmo_d     = tmo_q;

        if (fall) begin
            tmo_d = TMO_LOAD;
        end else if ((state_q != IDLE) && (tmo_q != '0)) begin
            tmo_d = tmo_q - TW'(1);
        end

        if (timeout_hit) begin
            state_d = IDLE;
        end else if (fall) begin
            unique case (state_q)
                IDLE: begin
                    if (!dat) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {dat, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_d   = dat;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Prefix layer and registered key event / error outputs
    always_comb begin
        ext_d     = ext_q;
        brk_d     = brk_q;
        keycode_d = keycode_q;
        make_d    = make_q;
        kext_d    = kext_q;
        valid_d   = 1'b0;
        err_d     = start_err | stop_err | timeout_hit;

        if (stop_err || timeout_hit) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_rdy) begin
            unique case (shift_q)
                PS2_EXT:   ext_d = 1'b1;
                PS2_BRK:   brk_d = 1'b1;
                PS2_PAUSE: ;
                default: begin
                    // Housekeeping codes only count as keys after a prefix
                    if (ext_q || brk_q || !is_suppressed(shift_q)) begin
                        keycode_d = shift_q;
                        make_d    = ~brk_q;
                        kext_d    = ext_q;
                        valid_d   = 1'b1;
                        ext_d     = 1'b0;
                        brk_d     = 1'b0;
                    end
                end
            endcase
        end
    end

    assign keycode   = keycode_q;
    assign key_make  = make_q;
    assign key_ext   = kext_q;
    assign key_valid = valid_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: a frame table plus hand sequences
// for timeout, glitch rejection, bad start bit and mid-frame reset.
module tb_ps2_key_decoder;

    localparam int HALF     = 10;   // clk cycles per PS/2 clock half-period
    localparam int TMO      = 100;
    // raw ps2_clk fall driven at a negedge -> fall strobe 6 cycles later
    localparam int FALL_LAT = 6;
    localparam int KV_LAT   = FALL_LAT + 1;
    localparam int ERR_LAT  = FALL_LAT + TMO;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] keycode;
    logic       key_make, key_ext, key_valid, frame_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_fall = 0;
    int kv_cnt = 0, kv_cyc = 0;
    int fe_cnt = 0, fe_cyc = 0;
    int both_cnt = 0;
    int hold_viol = 0;
    logic [9:0] prev_out = '0;
    logic       prev_rst = 1'b0;

    ps2_key_decoder #(
        .FILTER_LEN     (4),
        .TIMEOUT_CYCLES (TMO),
        .SYNC_STAGES    (2)
    ) dut (
        .clk       (clk),
        .reset     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .keycode   (keycode),
        .key_make  (key_make),
        .key_ext   (key_ext),
        .key_valid (key_valid),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse bookkeeping and held-output stability, sampled mid-cycle
    always @(negedge clk) begin
        if (key_valid) begin
            kv_cnt++;
            kv_cyc = cyc;
        end
        if (frame_err) begin
            fe_cnt++;
            fe_cyc = cyc;
        end
        if (key_valid && frame_err) both_cnt++;
        if (prev_rst && rst_n && !key_valid &&
            ({keycode, key_make, key_ext} != prev_out)) hold_viol++;
        prev_out = {keycode, key_make, key_ext};
        prev_rst = rst_n;
    end

    typedef struct {
        logic [7:0] d;
        logic       bad_par;
        logic       stop;
        int         e_kv;
        int         e_err;
        logic [7:0] e_code;
        logic       e_make;
        logic       e_ext;
    } vec_t;

    vec_t tbl[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] mk(input logic [7:0] d, input logic bad_par, input logic stop);
        return {stop, (~^d) ^ bad_par, d, 1'b0};
    endfunction

    // Send the first nbits of a frame; optionally inject a short low
    // glitch on ps2_clk during the high phase before bit glitch_at
    task automatic send_bits(input logic [10:0] bits, input int nbits, input int glitch_at);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_dat = bits[i];
            repeat (HALF) @(negedge clk);
            if (i == glitch_at) begin
                ps2_clk = 1'b0;
                repeat (3) @(negedge clk);
                ps2_clk = 1'b1;
                repeat (HALF) @(negedge clk);
            end
            ps2_clk   = 1'b0;
            last_fall = cyc;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        repeat (HALF) @(negedge clk);
        ps2_dat = 1'b1;
    endtask

    task automatic frame_check(input string tag, input logic [7:0] d, input int glitch_at,
                               input int e_kv, input int e_err,
                               input logic [7:0] e_code, input logic e_make, input logic e_ext);
        int kv0, fe0;
        kv0 = kv_cnt;
        fe0 = fe_cnt;
        send_bits(mk(d, 1'b0, 1'b1), 11, glitch_at);
        repeat (20) @(negedge clk);
        chk({tag, " kv"}, kv_cnt - kv0, e_kv);
        chk({tag, " err"}, fe_cnt - fe0, e_err);
        chk({tag, " code"}, keycode, e_code);
        chk({tag, " make"}, key_make, e_make);
        chk({tag, " ext"}, key_ext, e_ext);
    endtask

    initial begin
        int kv0, fe0;

        //          d      badp  stop  kv err code   make  ext
        tbl[0]  = '{8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C, 1'b1, 1'b0};
        tbl[1]  = '{8'hF0, 1'b0, 1'b1, 0, 0, 8'h1C, 1'b1, 1'b0};
        tbl[2]  = '{8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C, 1'b0, 1'b0};
        tbl[3]  = '{8'hE0, 1'b0, 1'b1, 0, 0, 8'h1C, 1'b0, 1'b0};
        tbl[4]  = '{8'h75, 1'b0, 1'b1, 1, 0, 8'h75, 1'b1, 1'b1};
        tbl[5]  = '{8'hE0, 1'b0, 1'b1, 0, 0, 8'h75, 1'b1, 1'b1};
        tbl[6]  = '{8'hF0, 1'b0, 1'b1, 0, 0, 8'h75, 1'b1, 1'b1};
        tbl[7]  = '{8'h75, 1'b0, 1'b1, 1, 0, 8'h75, 1'b0, 1'b1};
        tbl[8]  = '{8'h1C, 1'b1, 1'b1, 0, 1, 8'h75, 1'b0, 1'b1};
        tbl[9]  = '{8'hF0, 1'b0, 1'b1, 0, 0, 8'h75, 1'b0, 1'b1};
        tbl[10] = '{8'h1C, 1'b0, 1'b0, 0, 1, 8'h75, 1'b0, 1'b1};
        tbl[11] = '{8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C, 1'b1, 1'b0};
        tbl[12] = '{8'hAA, 1'b0, 1'b1, 0, 0, 8'h1C, 1'b1, 1'b0};
        tbl[13] = '{8'hE1, 1'b0, 1'b1, 0, 0, 8'h1C, 1'b1, 1'b0};
        tbl[14] = '{8'hE0, 1'b0, 1'b1, 0, 0, 8'h1C, 1'b1, 1'b0};
        tbl[15] = '{8'hAA, 1'b0, 1'b1, 1, 0, 8'hAA, 1'b1, 1'b1};
        tbl[16] = '{8'hFA, 1'b0, 1'b1, 0, 0, 8'hAA, 1'b1, 1'b1};
        tbl[17] = '{8'hF0, 1'b0, 1'b1, 0, 0, 8'hAA, 1'b1, 1'b1};
        tbl[18] = '{8'hE1, 1'b0, 1'b1, 0, 0, 8'hAA, 1'b1, 1'b1};
        tbl[19] = '{8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C, 1'b0, 1'b0};
        tbl[20] = '{8'h00, 1'b0, 1'b1, 0, 0, 8'h1C, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst code", keycode, 8'h00);
        chk("rst make", key_make, 1'b0);
        chk("rst ext", key_ext, 1'b0);
        chk("rst kv", key_valid, 1'b0);
        chk("rst err", frame_err, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Frame table
        for (int i = 0; i < 21; i++) begin
            kv0 = kv_cnt;
            fe0 = fe_cnt;
            send_bits(mk(tbl[i].d, tbl[i].bad_par, tbl[i].stop), 11, -1);
            repeat (20) @(negedge clk);
            chk($sformatf("vec%0d kv", i), kv_cnt - kv0, tbl[i].e_kv);
            chk($sformatf("vec%0d err", i), fe_cnt - fe0, tbl[i].e_err);
            chk($sformatf("vec%0d code", i), keycode, tbl[i].e_code);
            chk($sformatf("vec%0d make", i), key_make, tbl[i].e_make);
            chk($sformatf("vec%0d ext", i), key_ext, tbl[i].e_ext);
            if (tbl[i].e_kv == 1)
                chk($sformatf("vec%0d kv latency", i), kv_cyc - last_fall, KV_LAT);
        end

        // Start bit sampled high -> error only
        kv0 = kv_cnt;
        fe0 = fe_cnt;
        send_bits(11'h001, 1, -1);
        repeat (20) @(negedge clk);
        chk("bad start err", fe_cnt - fe0, 1);
        chk("bad start kv", kv_cnt - kv0, 0);

        // Timeout after a break prefix and five bits; flag must be dropped
        send_bits(mk(8'hF0, 1'b0, 1'b1), 11, -1);
        kv0 = kv_cnt;
        fe0 = fe_cnt;
        send_bits(mk(8'h1C, 1'b0, 1'b1), 5, -1);
        for (int i = 0; i < 3 * TMO && fe_cnt == fe0; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        chk("tmo err", fe_cnt - fe0, 1);
        chk("tmo latency", fe_cyc - last_fall, ERR_LAT);
        chk("tmo kv", kv_cnt - kv0, 0);
        chk("tmo held code", keycode, 8'h1C);
        chk("tmo held make", key_make, 1'b0);
        frame_check("post tmo", 8'h1C, -1, 1, 0, 8'h1C, 1'b1, 1'b0);

        // Sub-threshold glitch inside a frame
        frame_check("glitch", 8'h4D, 4, 1, 0, 8'h4D, 1'b1, 1'b0);

        // Reset in the middle of a frame
        send_bits(mk(8'h33, 1'b0, 1'b1), 4, -1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst code", keycode, 8'h00);
        chk("midrst make", key_make, 1'b0);
        chk("midrst ext", key_ext, 1'b0);
        chk("midrst kv", key_valid, 1'b0);
        chk("midrst err", frame_err, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        frame_check("post rst", 8'h29, -1, 1, 0, 8'h29, 1'b1, 1'b0);

        chk("kv and err together", both_cnt, 0);
        chk("held output changed without kv", hold_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
